// File: rtl/pool_writeback.sv
// pool_writeback: captures pooled words with their output position, computes the
// feature-memory word address, buffers them in a small FIFO and drains the FIFO
// into the memory write port under mem_ready backpressure. done pulses once every
// word of the layer has been written.
// Build option: define POOL_WB_RELU_EN to clamp negative channels to zero at pop.
module pool_writeback #(
    parameter int DATA_WIDTH       = 16,
    parameter int POOL_PARALLELISM = 8,
    parameter int ADDR_WIDTH       = 16,
    parameter int FIFO_DEPTH       = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [7:0]                             out_size,
    input  logic [7:0]                             channel,
    input  logic [ADDR_WIDTH-1:0]                  base_addr,
    input  logic                                   in_valid,
    input  logic [DATA_WIDTH*POOL_PARALLELISM-1:0] in_data,
    input  logic [7:0]                             in_h,
    input  logic [7:0]                             in_w,
    input  logic [7:0]                             in_chsel,
    input  logic                                   mem_ready,
    output logic                                   mem_we,
    output logic [ADDR_WIDTH-1:0]                  mem_addr,
    output logic [DATA_WIDTH*POOL_PARALLELISM-1:0] mem_wdata,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   overflow
);

    localparam int WW = DATA_WIDTH * POOL_PARALLELISM;
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                state, state_nx;
    logic [7:0]            cfg_size;
    logic [7:0]            cfg_groups;
    logic [ADDR_WIDTH-1:0] cfg_base;
    logic [15:0]           total;
    logic [15:0]           push_cnt;
    logic [15:0]           write_cnt;

    logic [WW-1:0]         fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;

    logic                  full, empty, push, pop, drop, start_ok;
    logic [7:0]            groups_new;
    logic [ADDR_WIDTH-1:0] push_addr;

    function automatic logic [WW-1:0] relu_clamp(input logic [WW-1:0] d);
        logic [WW-1:0] r;
        r = d;
`ifdef POOL_WB_RELU_EN
        for (int unsigned j = 0; j < POOL_PARALLELISM; j++) begin
            if (d[DATA_WIDTH*j + DATA_WIDTH-1]) r[DATA_WIDTH*j +: DATA_WIDTH] = '0;
        end
`endif
        return r;
    endfunction

    assign full     = (count == (PW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign start_ok = start && (state == S_IDLE);
    assign pop      = ((state == S_RUN) || (state == S_DRAIN)) && !empty && mem_ready;
    assign push     = (state == S_RUN) && in_valid && (!full || pop);
    assign drop     = in_valid && (((state == S_RUN) && full && !pop) || (state == S_DRAIN));
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    assign groups_new = 8'((9'(channel) + 9'(POOL_PARALLELISM - 1)) / 9'(POOL_PARALLELISM));
    assign push_addr  = ADDR_WIDTH'(32'(cfg_base)
                        + (32'(in_h) * 32'(cfg_size) + 32'(in_w)) * 32'(cfg_groups)
                        + 32'(in_chsel) / 32'(POOL_PARALLELISM));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (push && (push_cnt + 16'd1 == total)) state_nx = S_DRAIN;
            S_DRAIN: if (empty && (write_cnt == total)) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Layer configuration, progress counters and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_size   <= '0;
            cfg_groups <= '0;
            cfg_base   <= '0;
            total      <= '0;
            push_cnt   <= '0;
            write_cnt  <= '0;
            overflow   <= 1'b0;
        end else if (start_ok) begin
            cfg_size   <= out_size;
            cfg_groups <= groups_new;
            cfg_base   <= base_addr;
            total      <= 16'(32'(out_size) * 32'(out_size) * 32'(groups_new));
            push_cnt   <= '0;
            write_cnt  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) push_cnt  <= push_cnt + 16'd1;
            if (pop)  write_cnt <= write_cnt + 16'd1;
            if (drop) overflow  <= 1'b1;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= in_data;
            fifo_addr[wr_ptr] <= push_addr;
        end
    end

    // Registered memory write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= pop;
            if (pop) begin
                mem_addr  <= fifo_addr[rd_ptr];
                mem_wdata <= relu_clamp(fifo_data[rd_ptr]);
            end
        end
    end

endmodule

// File: tb/tb_pool_writeback.sv
// Self-checking bench for pool_writeback: queue-based reference model feeds a
// scoreboard; a negedge monitor compares every memory write in order.
module tb_pool_writeback;

    localparam int DW  = 16;
    localparam int PCP = 8;
    localparam int AW  = 16;
    localparam int D   = 8;
    localparam int WW  = DW * PCP;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    out_size = '0, channel = '0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic [WW-1:0] in_data = '0;
    logic [7:0]    in_h = '0, in_w = '0, in_chsel = '0;
    logic          mem_ready = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic          busy, done, overflow;

    pool_writeback #(.DATA_WIDTH(DW), .POOL_PARALLELISM(PCP), .ADDR_WIDTH(AW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .out_size(out_size), .channel(channel),
        .base_addr(base_addr), .in_valid(in_valid), .in_data(in_data), .in_h(in_h),
        .in_w(in_w), .in_chsel(in_chsel), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wr_t;

    wr_t m_fifo[$];
    wr_t exp_q[$];
    wr_t wr_log[$];

    int  n_cmp = 0, n_fail = 0;
    int  cyc = 0;
    int  we_cnt = 0, last_we_cyc = 0, done_cnt = 0, done_cyc = 0;
    bit  m_started = 0, m_ovf = 0;
    int  m_pushed = 0, m_total = 0, m_os = 0, m_cg = 0, m_base = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [WW-1:0] ref_data(input logic [WW-1:0] d);
        logic [WW-1:0] r;
        r = d;
`ifdef POOL_WB_RELU_EN
        for (int j = 0; j < PCP; j++) begin
            if ($signed(d[DW*j +: DW]) < 0) r[DW*j +: DW] = '0;
        end
`endif
        return r;
    endfunction

    // Monitor: every write must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            we_cnt++;
            last_we_cyc = cyc;
            wr_log.push_back('{mem_addr, mem_wdata});
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h, expected no write", mem_addr);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", WW'(mem_addr), WW'(w.addr));
                chk("wr_data", mem_wdata, w.data);
            end
        end
        if (rst_n && done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Advance one clock; the reference model consumes the inputs seen at this edge
    task automatic step();
        bit pop, acc, running;
        wr_t w;
        running = m_started && (m_pushed < m_total);
        pop = m_started && (m_fifo.size() > 0) && mem_ready;
        acc = in_valid && running && ((m_fifo.size() < D) || pop);
        if (pop) begin
            w = m_fifo.pop_front();
            w.data = ref_data(w.data);
            exp_q.push_back(w);
        end
        if (acc) begin
            w.addr = AW'(m_base + (int'(in_h) * m_os + int'(in_w)) * m_cg + int'(in_chsel) / PCP);
            w.data = in_data;
            m_fifo.push_back(w);
            m_pushed++;
        end
        if (in_valid && running && !acc) m_ovf = 1;
        if (start && !m_started) begin
            m_started = 1;
            m_os      = int'(out_size);
            m_cg      = (int'(channel) + PCP - 1) / PCP;
            m_total   = (m_os * m_os * m_cg) % 65536;
            m_base    = int'(base_addr);
            m_pushed  = 0;
            m_ovf     = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int os, input int ch, input int base);
        out_size  = 8'(os);
        channel   = 8'(ch);
        base_addr = AW'(base);
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic set_word(input int h, input int w, input int g, input logic [WW-1:0] d);
        in_valid = 1'b1;
        in_h     = 8'(h);
        in_w     = 8'(w);
        in_chsel = 8'(g * PCP);
        in_data  = d;
    endtask

    function automatic logic [WW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic hard_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        #1;
        m_fifo.delete();
        exp_q.delete();
        m_started = 0;
        m_ovf = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    // Wait for done; check its timing relative to the last write and the idle state after it
    task automatic finish_layer(input string nm);
        int d0, n;
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < 300) begin
            step();
            n++;
        end
        if (done_cnt == d0) begin
            chk({nm, "_done_timeout"}, 0, 1);
        end else begin
            chk({nm, "_done_lat"}, WW'(done_cyc - last_we_cyc), WW'(1));
            chk({nm, "_busy_after"}, WW'(busy), WW'(0));
            chk({nm, "_done_width"}, WW'(done), WW'(0));
        end
        chk({nm, "_pending"}, WW'(exp_q.size()), WW'(0));
        chk({nm, "_ovf"}, WW'(overflow), WW'(m_ovf));
        m_started = 0;
    endtask

    // Feed every word of the layer in random order with random gaps and backpressure
    task automatic random_layer(input string nm, input int os, input int ch, input int base,
                                input int ready_pct, input int gap_pct);
        int words[$];
        int cg, tries, tmp, j;
        cg = (ch + PCP - 1) / PCP;
        do_start(os, ch, base);
        for (int i = 0; i < os * os * cg; i++) words.push_back(i);
        for (int i = words.size() - 1; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = words[i];
            words[i] = words[j];
            words[j] = tmp;
        end
        foreach (words[k]) begin
            tries = 0;
            forever begin
                mem_ready = ($urandom_range(99, 0) < ready_pct);
                if (($urandom_range(99, 0) >= gap_pct) && ((m_fifo.size() < D) || mem_ready)) begin
                    set_word(words[k] / (os * cg) , (words[k] / cg) % os, words[k] % cg, rand_word());
                    step();
                    in_valid = 1'b0;
                    break;
                end
                in_valid = 1'b0;
                step();
                tries++;
                if (tries > 100) begin
                    chk({nm, "_feed_timeout"}, 0, 1);
                    break;
                end
            end
        end
        finish_layer(nm);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_we", WW'(mem_we), 0);
        chk("rst_addr", WW'(mem_addr), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", WW'(busy), 0);
        chk("rst_done", WW'(done), 0);
        chk("rst_ovf", WW'(overflow), 0);
        hard_reset();

        // T1 + T4: raster layer, back-to-back, first word carries a negative channel
        begin
            logic [WW-1:0] d;
            int k;
            do_start(2, 16, 'h100);
            mem_ready = 1'b1;
            wr_log.delete();
            k = 0;
            for (int h = 0; h < 2; h++)
                for (int w = 0; w < 2; w++)
                    for (int g = 0; g < 2; g++) begin
                        d = rand_word();
                        if (k == 0) begin
                            d[15:0]  = 16'hFFF0;
                            d[31:16] = 16'h0010;
                        end
                        set_word(h, w, g, d);
                        step();
                        k++;
                    end
            finish_layer("t1");
            chk("t1_nwrites", WW'(wr_log.size()), WW'(8));
            if (wr_log.size() == 8) begin
                chk("t1_first_addr", WW'(wr_log[0].addr), WW'(16'h100));
                chk("t1_last_addr", WW'(wr_log[7].addr), WW'(16'h107));
`ifdef POOL_WB_RELU_EN
                chk("t4_ch0", WW'(wr_log[0].data[15:0]), WW'(16'h0000));
`else
                chk("t4_ch0", WW'(wr_log[0].data[15:0]), WW'(16'hFFF0));
`endif
                chk("t4_ch1", WW'(wr_log[0].data[31:16]), WW'(16'h0010));
            end
        end

        // T2: 12 channels -> 2 groups; (1,1,chsel=8) lands on address 7
        begin
            do_start(2, 12, 0);
            mem_ready = 1'b1;
            wr_log.delete();
            for (int h = 0; h < 2; h++)
                for (int w = 0; w < 2; w++)
                    for (int g = 0; g < 2; g++) begin
                        set_word(h, w, g, rand_word());
                        step();
                    end
            finish_layer("t2");
            if (wr_log.size() == 8) chk("t2_addr7", WW'(wr_log[7].addr), WW'(7));
            else chk("t2_nwrites", WW'(wr_log.size()), WW'(8));
        end

        // T6: full FIFO with same-cycle push and pop
        begin
            int we0;
            do_start(3, 8, 'h40);
            mem_ready = 1'b0;
            for (int i = 0; i < 8; i++) begin
                set_word(i / 3, i % 3, 0, rand_word());
                step();
            end
            we0 = we_cnt;
            set_word(2, 2, 0, rand_word());
            mem_ready = 1'b1;
            step();
            in_valid = 1'b0;
            mem_ready = 1'b0;
            chk("t6_ovf", WW'(overflow), 0);
            for (int i = 0; i < 3; i++) step();
            chk("t6_held", WW'(we_cnt - we0), WW'(1));
            finish_layer("t6");
        end

        // T3: backpressure overflow; layer cannot complete
        begin
            int we0, d0;
            do_start(4, 8, 'h200);
            mem_ready = 1'b0;
            for (int i = 0; i < 9; i++) begin
                set_word(i / 4, i % 4, 0, rand_word());
                step();
                if (i == 7) chk("t3_ovf_before", WW'(overflow), 0);
            end
            in_valid = 1'b0;
            chk("t3_ovf_after", WW'(overflow), WW'(m_ovf));
            chk("t3_ovf_set", WW'(overflow), 1);
            we0 = we_cnt;
            d0 = done_cnt;
            mem_ready = 1'b1;
            for (int i = 0; i < 20; i++) step();
            chk("t3_nwrites", WW'(we_cnt - we0), WW'(8));
            chk("t3_no_done", WW'(done_cnt - d0), 0);
            chk("t3_busy", WW'(busy), 1);
            hard_reset();
        end

        // T5: reset mid-layer after 3 writes, then a clean layer
        begin
            int we0, n;
            do_start(2, 16, 'h300);
            mem_ready = 1'b1;
            we0 = we_cnt;
            n = 0;
            while (we_cnt - we0 < 3 && n < 50) begin
                set_word(n / 4, (n / 2) % 2, n % 2, rand_word());
                step();
                n++;
            end
            in_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            chk("t5_we", WW'(mem_we), 0);
            chk("t5_addr", WW'(mem_addr), 0);
            chk("t5_wdata", mem_wdata, 0);
            chk("t5_busy", WW'(busy), 0);
            m_fifo.delete();
            exp_q.delete();
            m_started = 0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            we0 = we_cnt;
            for (int i = 0; i < 5; i++) step();
            chk("t5_no_writes", WW'(we_cnt - we0), 0);
            random_layer("t5_new", 2, 16, 'h300, 100, 0);
        end

        // Randomised layers, including address wrap near the top of memory
        random_layer("rnd0", 1, 1, int'($urandom_range(65535, 0)), 70, 30);
        random_layer("rnd1", 3, int'($urandom_range(24, 1)), 'hFFF8, 60, 30);
        random_layer("rnd2", int'($urandom_range(3, 1)), int'($urandom_range(24, 1)),
                     int'($urandom_range(65535, 0)), 50, 20);
        random_layer("rnd3", 3, 20, int'($urandom_range(65535, 0)), 30, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
